// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage request/response bundle between the pipeline (master) and the MDU (slave).
interface mdu_ctrl_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        d_mdu;
    logic        busy;
    logic        stall;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush, d_mdu,
        input  busy, stall, rd_data, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, d_mdu,
        output busy, stall, rd_data, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer owning HI/LO, with a busy counter and hazard stall request.
// Define MDU_MADD_EN to accept madd/maddu/msub/msubu (HI/LO accumulate, MULT_CYCLES latency).
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MFHI  = 4'b0101;
    localparam logic [3:0] OP_MFLO  = 4'b0110;
    localparam logic [3:0] OP_MTHI  = 4'b0111;
    localparam logic [3:0] OP_MTLO  = 4'b1000;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'b1001;
    localparam logic [3:0] OP_MADDU = 4'b1010;
    localparam logic [3:0] OP_MSUB  = 4'b1011;
    localparam logic [3:0] OP_MSUBU = 4'b1100;
`endif

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    // How the pending 64-bit value lands in {hi,lo} at commit.
    typedef enum logic [1:0] {
        K_NONE,
        K_SET,
        K_ADD,
        K_SUB
    } kind_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [63:0]       pend_q, pend_d;
    kind_t             kind_q, kind_d, acc_kind;
    logic [31:0]       hi_q, lo_q;

    logic        is_mul, is_div, is_signed, accept, commit;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, quot_mag, rem_mag, quot, rem;
    logic [63:0] prod_mag, prod;

    // Opcode decode.
    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        acc_kind  = K_SET;
        case (bus.op)
            OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_mul = 1'b1; is_signed = 1'b1; acc_kind = K_ADD; end
            OP_MADDU: begin is_mul = 1'b1; acc_kind = K_ADD; end
            OP_MSUB:  begin is_mul = 1'b1; is_signed = 1'b1; acc_kind = K_SUB; end
            OP_MSUBU: begin is_mul = 1'b1; acc_kind = K_SUB; end
`endif
            default: ;
        endcase
        accept = bus.start & ~bus.flush & (state_q == S_IDLE) & (is_mul | is_div);
    end

    // Sign-magnitude datapath: one unsigned multiplier/divider serves both signednesses,
    // which also makes 0x80000000 / -1 wrap to 0x80000000 without special casing.
    always_comb begin
        a_neg    = is_signed & bus.a[31];
        b_neg    = is_signed & bus.b[31];
        a_mag    = a_neg ? (32'd0 - bus.a) : bus.a;
        b_mag    = b_neg ? (32'd0 - bus.b) : bus.b;
        prod_mag = {32'd0, a_mag} * {32'd0, b_mag};
        prod     = (a_neg ^ b_neg) ? (64'd0 - prod_mag) : prod_mag;
        quot_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
        rem_mag  = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
        quot     = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
        rem      = a_neg ? (32'd0 - rem_mag) : rem_mag;
        pend_d   = is_div ? {rem, quot} : prod;
        kind_d   = (is_div && (b_mag == 32'd0)) ? K_NONE : acc_kind;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_BUSY;
            S_BUSY: if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        commit      = (state_q == S_BUSY) && (cnt_q == CNT_W'(1));
        bus.busy    = (state_q == S_BUSY);
        bus.stall   = bus.d_mdu & ((state_q == S_BUSY) | (bus.start & ~bus.flush));
        bus.hi      = hi_q;
        bus.lo      = lo_q;
        bus.rd_data = 32'd0;
        case (bus.op)
            OP_MFHI: bus.rd_data = hi_q;
            OP_MFLO: bus.rd_data = lo_q;
            default: ;
        endcase
    end

    // Counter, pending result and HI/LO; a commit and an accept never share a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= '0;
            kind_q <= K_NONE;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (accept) begin
                cnt_q  <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                pend_q <= pend_d;
                kind_q <= kind_d;
            end else if (state_q == S_BUSY) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (commit) begin
                case (kind_q)
                    K_SET:   {hi_q, lo_q} <= pend_q;
                    K_ADD:   {hi_q, lo_q} <= {hi_q, lo_q} + pend_q;
                    K_SUB:   {hi_q, lo_q} <= {hi_q, lo_q} - pend_q;
                    default: ;
                endcase
            end else if ((state_q == S_IDLE) && !bus.flush) begin
                if (bus.op == OP_MTHI) hi_q <= bus.a;
                if (bus.op == OP_MTLO) lo_q <= bus.a;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed plus randomized checks of mdu_ctrl against a 64-bit arithmetic reference model.
module tb_mdu_ctrl;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    mdu_ctrl_if bus();

    mdu_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.flush = 1'b0;
        bus.d_mdu = 1'b0;
    endtask

    function automatic bit is_start_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 4'd1) && (op <= 4'd4 || (op >= 4'd9 && op <= 4'd12));
`else
        return (op >= 4'd1) && (op <= 4'd4);
`endif
    endfunction

    // Reference: new {hi,lo} for a start-class op given the accumulator at commit time.
    function automatic logic [63:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        case (op)
            4'd1:  return 64'(sa * sb);
            4'd2:  return 64'(ua * ub);
            4'd3:  return (b == 0) ? acc : {32'(sa % sb), 32'(sa / sb)};
            4'd4:  return (b == 0) ? acc : {32'(ua % ub), 32'(ua / ub)};
            4'd9:  return acc + 64'(sa * sb);
            4'd10: return acc + 64'(ua * ub);
            4'd11: return acc - 64'(sa * sb);
            4'd12: return acc - 64'(ua * ub);
            default: return acc;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, bus.hi, m_hi);
        check({tag, "_lo"}, bus.lo, m_lo);
    endtask

    // One start attempt; optional noise drives starts/mthi/mtlo that must be ignored while busy.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic fl, input logic dm, input bit noise);
        bit          acc;
        logic [63:0] exp_acc;
        int          n;
        acc     = is_start_op(op) && !fl;
        exp_acc = acc ? ref_op(op, a, b, {m_hi, m_lo}) : {m_hi, m_lo};
        n       = (op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.flush = fl; bus.d_mdu = dm;
        #1 check("stall_start", bus.stall, dm & ~fl);
        tick();
        idle_inputs();
        bus.d_mdu = dm;
        if (acc) begin
            for (int i = 0; i < n; i++) begin
                if (noise && $urandom_range(0, 1) == 1) begin
                    bus.start = 1'b1;
                    bus.op    = 4'($urandom_range(1, 8));
                    bus.a     = $urandom;
                    bus.b     = $urandom;
                end else begin
                    bus.start = 1'b0;
                    bus.op    = 4'd0;
                end
                #1;
                check("busy_hold", bus.busy, 1);
                if (dm) check("stall_busy", bus.stall, 1);
                tick();
            end
            idle_inputs();
            bus.d_mdu = dm;
            #1;
            if (dm) check("stall_fall", bus.stall, 0);
        end
        check("busy_end", bus.busy, 0);
        {m_hi, m_lo} = exp_acc;
        check_regs("result");
        bus.op = 4'b0101;
        #1 check("rd_mfhi", bus.rd_data, m_hi);
        bus.op = 4'b0110;
        #1 check("rd_mflo", bus.rd_data, m_lo);
        bus.op = 4'd0;
        #1 check("rd_none", bus.rd_data, 0);
        bus.d_mdu = 1'b0;
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] a, input logic fl);
        bus.start = 1'b0; bus.op = op; bus.a = a; bus.flush = fl;
        tick();
        idle_inputs();
        if (!fl) begin
            if (op == 4'b0111) m_hi = a;
            if (op == 4'b1000) m_lo = a;
        end
        check_regs("mt");
    endtask

    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;

    initial begin
        idle_inputs();
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        reset = 1'b1;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_stall", bus.stall, 0);
        check_regs("rst");
        tick();
        tick();
        reset = 1'b0;
        tick();

        run_op(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 1'b0);
        check("mult_hi_k", bus.hi, 32'hFFFFFFFF);
        check("mult_lo_k", bus.lo, 32'hFFFFFFFE);
        run_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, 1'b0);
        check("multu_hi_k", bus.hi, 32'h00000001);
        check("multu_lo_k", bus.lo, 32'hFFFFFFFE);
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        check("div_lo_k", bus.lo, 32'hFFFFFFFD);
        check("div_hi_k", bus.hi, 32'hFFFFFFFF);
        run_op(4'd4, 32'd123, 32'd0, 1'b0, 1'b0, 1'b0);
        check("divz_hi_k", bus.hi, 32'hFFFFFFFF);
        check("divz_lo_k", bus.lo, 32'hFFFFFFFD);
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        check("divovf_lo_k", bus.lo, 32'h80000000);
        check("divovf_hi_k", bus.hi, 32'h00000000);

        run_op(4'd1, 32'h00001234, 32'h00000010, 1'b0, 1'b1, 1'b0);
        check("stall_mflo_k", bus.lo, 32'h00012340);
        run_op(4'd2, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0);
        check("flush_lo_k", bus.lo, 32'h00012340);

        mt(4'b0111, 32'h00001234, 1'b1);
        check("mthi_flush_k", bus.hi, 32'h00000000);
        mt(4'b0111, 32'h00001234, 1'b0);
        check("mthi_k", bus.hi, 32'h00001234);

        // Reset three cycles into a divide: immediate clear and no late commit.
        mt(4'b1000, 32'hCAFEF00D, 1'b0);
        bus.start = 1'b1; bus.op = 4'd3; bus.a = 32'd100; bus.b = 32'd7;
        tick();
        idle_inputs();
        tick();
        tick();
        #1 check("pre_rst_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        check("async_busy", bus.busy, 0);
        check("async_hi", bus.hi, 0);
        check("async_lo", bus.lo, 0);
        tick();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        repeat (DIV_N + 2) tick();
        check("post_rst_busy", bus.busy, 0);
        check_regs("post_rst");

`ifdef MDU_MADD_EN
        mt(4'b0111, 32'd0, 1'b0);
        mt(4'b1000, 32'hFFFFFFFF, 1'b0);
        run_op(4'd10, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        check("maddu_hi_k", bus.hi, 32'd1);
        check("maddu_lo_k", bus.lo, 32'd0);
`else
        bus.start = 1'b1; bus.op = 4'd9; bus.a = 32'd3; bus.b = 32'd4;
        tick();
        idle_inputs();
        check("nomadd_busy", bus.busy, 0);
        check_regs("nomadd");
`endif

        for (int k = 0; k < 60; k++) begin
            r_op = 4'($urandom_range(1, 12));
            case ($urandom_range(0, 2))
                0: r_a = 32'h80000000;
                1: r_a = 32'($urandom_range(0, 50));
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: r_b = 32'd0;
                1: r_b = 32'hFFFFFFFF;
                2: r_b = 32'($urandom_range(1, 9));
                default: r_b = $urandom;
            endcase
            if (r_op == 4'b0111 || r_op == 4'b1000)
                mt(r_op, r_a, 1'($urandom_range(0, 3) == 0));
            else
                run_op(r_op, r_a, r_b, 1'($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 1)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
